prt_scaler_lbuf_rd: RTL



---
 rtl/prt_scaler_lbuf_rd.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/prt_scaler_lbuf_rd.sv
// Line buffer read controller: drains one line from a 1-cycle-latency RAM read port
// into a 4-entry buffer and emits it as a valid/ready pixel stream with optional repeat.
module prt_scaler_lbuf_rd #(
    parameter int unsigned P_ADR_WIDTH = 11,
    parameter int unsigned P_DAT_WIDTH = 48
) (
    input  logic                   CLK_IN,
    input  logic                   RST_IN,
    input  logic                   CLR_IN,
    input  logic                   START_IN,
    input  logic [P_ADR_WIDTH-1:0] BASE_IN,
    input  logic [P_ADR_WIDTH-1:0] LEN_IN,
    input  logic [1:0]             REP_IN,
    output logic [P_ADR_WIDTH-1:0] RAM_ADR_OUT,
    output logic                   RAM_RD_OUT,
    input  logic [P_DAT_WIDTH-1:0] RAM_DAT_IN,
    output logic [P_DAT_WIDTH-1:0] DAT_OUT,
    output logic                   VLD_OUT,
    input  logic                   RDY_IN,
    output logic                   LAST_OUT,
    output logic                   BUSY_OUT,
    output logic                   DONE_OUT
);

    localparam int unsigned CNT_W = P_ADR_WIDTH + 1;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned OCC_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 state, state_d;
    logic [P_ADR_WIDTH-1:0] adr_d;
    logic                   rd_d;
    logic                   rd_q;
    logic [CNT_W-1:0]       remaining, remaining_d;
    logic [CNT_W-1:0]       left, left_d;
    logic [1:0]             rep_q, rep_q_d;
    logic [1:0]             rep_cnt, rep_cnt_d;
    logic [PTR_W-1:0]       wr_ptr, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr, rd_ptr_d;
    logic [OCC_W-1:0]       occ, occ_d;
    logic                   vld_d;
    logic                   last_d;
    logic                   busy_d;
    logic                   done_d;
    logic                   push;
    logic                   pop;
    logic                   hs;
    logic                   budget_ok;
    logic [P_DAT_WIDTH-1:0] mem_q [DEPTH];

    assign DAT_OUT = mem_q[rd_ptr];

    // Next-state, fetch and emit bookkeeping
    always_comb begin
        state_d     = state;
        adr_d       = RAM_ADR_OUT;
        rd_d        = 1'b0;
        remaining_d = remaining;
        left_d      = left;
        rep_q_d     = rep_q;
        rep_cnt_d   = rep_cnt;
        wr_ptr_d    = wr_ptr;
        rd_ptr_d    = rd_ptr;
        occ_d       = occ;
        done_d      = 1'b0;
        push        = 1'b0;
        hs          = VLD_OUT && RDY_IN;
        pop         = hs && (rep_cnt == rep_q);
        // in-flight reads are the one on the bus now and the one returning now
        budget_ok   = (occ + OCC_W'(RAM_RD_OUT) + OCC_W'(rd_q)) < OCC_W'(DEPTH);

        if (CLR_IN) begin
            state_d     = S_IDLE;
            remaining_d = '0;
            left_d      = '0;
            rep_cnt_d   = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            occ_d       = '0;
            pop         = 1'b0;
        end else begin
            push = rd_q;
            if (push) begin
                wr_ptr_d = wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr + PTR_W'(1);
                rep_cnt_d = '0;
                left_d    = left - CNT_W'(1);
            end else if (hs) begin
                rep_cnt_d = rep_cnt + 2'(1);
            end
            occ_d = occ + OCC_W'(push) - OCC_W'(pop);

            case (state)
                S_IDLE: begin
                    if (START_IN) begin
                        if (LEN_IN != '0) begin
                            state_d     = S_RUN;
                            adr_d       = BASE_IN;
                            rd_d        = 1'b1;
                            remaining_d = CNT_W'(LEN_IN) - CNT_W'(1);
                            left_d      = CNT_W'(LEN_IN);
                            rep_q_d     = REP_IN;
                            rep_cnt_d   = '0;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (remaining == '0) begin
                        state_d = S_DRAIN;
                    end else if (budget_ok) begin
                        rd_d        = 1'b1;
                        adr_d       = RAM_ADR_OUT + P_ADR_WIDTH'(1);
                        remaining_d = remaining - CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (pop && (left == CNT_W'(1))) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        vld_d  = (occ_d != '0);
        last_d = vld_d && (left_d == CNT_W'(1)) && (rep_cnt_d == rep_q_d);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state       <= S_IDLE;
            RAM_ADR_OUT <= '0;
            RAM_RD_OUT  <= 1'b0;
            rd_q        <= 1'b0;
            remaining   <= '0;
            left        <= '0;
            rep_q       <= '0;
            rep_cnt     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            VLD_OUT     <= 1'b0;
            LAST_OUT    <= 1'b0;
            BUSY_OUT    <= 1'b0;
            DONE_OUT    <= 1'b0;
        end else begin
            state       <= state_d;
            RAM_ADR_OUT <= adr_d;
            RAM_RD_OUT  <= rd_d;
            rd_q        <= RAM_RD_OUT && !CLR_IN;
            remaining   <= remaining_d;
            left        <= left_d;
            rep_q       <= rep_q_d;
            rep_cnt     <= rep_cnt_d;
            wr_ptr      <= wr_ptr_d;
            rd_ptr      <= rd_ptr_d;
            occ         <= occ_d;
            VLD_OUT     <= vld_d;
            LAST_OUT    <= last_d;
            BUSY_OUT    <= busy_d;
            DONE_OUT    <= done_d;
        end
    end

    // Capture returning read data one cycle after the strobe
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr] <= RAM_DAT_IN;
        end
    end

endmodule
